// File: rtl/branch_predictor.sv
// Direct-mapped branch history table plus branch target buffer.
// Zero-latency lookup by fetch PC; trained one edge later by resolved branches.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_pred_taken,
    output logic [31:0] mispredict_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];
    logic [31:0]      cnt_q, cnt_d;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[31:IDX_W+2];

    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign pred_taken  = f_hit && ctr_q[f_idx][1];
    assign pred_target = pred_taken ? tgt_q[f_idx] : fetch_pc + 32'd4;

    // Only direction errors count; a wrong target on a correct direction does not.
    always_comb begin
        cnt_d = cnt_q;
        if (update_valid && (update_pred_taken != update_taken)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
                tgt_q[i]   <= '0;
            end
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (update_valid) begin
                if (u_hit) begin
                    if (update_taken) begin
                        ctr_q[u_idx] <= sat_inc(ctr_q[u_idx]);
                        tgt_q[u_idx] <= update_target;
                    end else begin
                        ctr_q[u_idx] <= sat_dec(ctr_q[u_idx]);
                    end
                end else if (update_taken) begin
                    // Taken miss evicts whatever alias occupies the slot.
                    valid_q[u_idx] <= 1'b1;
                    tag_q[u_idx]   <= u_tag;
                    ctr_q[u_idx]   <= 2'b10;
                    tgt_q[u_idx]   <= update_target;
                end
            end
        end
    end

    assign mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table then randomized traffic
// compared against an array-based reference model.
module tb_branch_predictor;
    localparam int ENTRIES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_pred_taken;
    logic [31:0] mispredict_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk(clk),
        .rst(rst),
        .fetch_pc(fetch_pc),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .update_valid(update_valid),
        .update_pc(update_pc),
        .update_taken(update_taken),
        .update_target(update_target),
        .update_pred_taken(update_pred_taken),
        .mispredict_cnt(mispredict_cnt)
    );

    typedef struct {
        logic        rst;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        up;
        logic [31:0] fpc;
        logic        et;
        logic [31:0] etgt;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                                logic up, logic [31:0] fpc, logic et, logic [31:0] etgt,
                                logic [31:0] ecnt);
        vec_t v;
        v.rst = r; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.up = up;
        v.fpc = fpc; v.et = et; v.etgt = etgt; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic up, input logic [31:0] fpc);
        rst = r; update_valid = uv; update_pc = upc; update_taken = ut;
        update_target = utgt; update_pred_taken = up; fetch_pc = fpc;
    endtask

    // Reference model: plain arrays, counter kept as an integer 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    logic [31:0] m_cnt;

    function automatic int pidx(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned ptag(logic [31:0] pc);
        return int'(pc / (4 * ENTRIES));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = '0;
        end
        m_cnt = '0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        int i;
        i = pidx(pc);
        t = m_valid[i] && (m_tag[i] == ptag(pc)) && (m_ctr[i] >= 2);
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_update(input logic r, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt, input logic up);
        int i;
        bit hit;
        if (r) begin
            model_reset();
            return;
        end
        if (!uv) return;
        if (up != ut) m_cnt = m_cnt + 32'd1;
        i = pidx(upc);
        hit = m_valid[i] && (m_tag[i] == ptag(upc));
        if (hit && ut) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = utgt;
        end else if (hit) begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (ut) begin
            m_valid[i] = 1; m_tag[i] = ptag(upc); m_ctr[i] = 2; m_tgt[i] = utgt;
        end
    endtask

    logic [31:0] pool [8];

    initial begin
        logic        et;
        logic [31:0] etgt;
        logic [31:0] upc, fpc;
        logic        uv, ut, up, r;

        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 32'h100);
        repeat (2) @(posedge clk);

        //     rst  uv  upc       ut  utgt      up  fpc       et  etgt      cnt
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h104, 0));
        vecs.push_back(mk(0, 1, 32'h100, 1, 32'h080, 0, 32'h100, 0, 32'h104, 0));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 32'h080, 1));
        vecs.push_back(mk(0, 1, 32'h100, 1, 32'h080, 1, 32'h100, 1, 32'h080, 1));
        vecs.push_back(mk(0, 1, 32'h100, 1, 32'h080, 1, 32'h100, 1, 32'h080, 1));
        vecs.push_back(mk(0, 1, 32'h100, 1, 32'h080, 1, 32'h100, 1, 32'h080, 1));
        vecs.push_back(mk(0, 1, 32'h100, 0, 32'h000, 1, 32'h100, 1, 32'h080, 1));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 32'h080, 2));
        vecs.push_back(mk(0, 1, 32'h100, 0, 32'h000, 1, 32'h100, 1, 32'h080, 2));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h104, 3));
        vecs.push_back(mk(0, 1, 32'h100, 0, 32'h000, 0, 32'h100, 0, 32'h104, 3));
        vecs.push_back(mk(0, 1, 32'h100, 0, 32'h000, 0, 32'h100, 0, 32'h104, 3));
        vecs.push_back(mk(0, 1, 32'h100, 0, 32'h000, 0, 32'h100, 0, 32'h104, 3));
        // From 00 one taken update must only reach 01: still not taken.
        vecs.push_back(mk(0, 1, 32'h100, 1, 32'h080, 0, 32'h100, 0, 32'h104, 3));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h104, 4));
        vecs.push_back(mk(0, 1, 32'h140, 1, 32'h200, 0, 32'h140, 0, 32'h144, 4));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h104, 5));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 32'h140, 1, 32'h200, 5));
        vecs.push_back(mk(0, 1, 32'h300, 0, 32'h000, 0, 32'h300, 0, 32'h304, 5));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 32'h300, 0, 32'h304, 5));
        // Reset with a concurrent mispredicting update: update is dropped.
        vecs.push_back(mk(1, 1, 32'h140, 1, 32'h400, 0, 32'h140, 1, 32'h200, 5));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 32'h140, 0, 32'h144, 0));
        vecs.push_back(mk(0, 0, 32'h000, 0, 32'h000, 0, 32'hFFFF_FFFC, 0, 32'h0, 0));

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].uv, vecs[k].upc, vecs[k].ut, vecs[k].utgt,
                  vecs[k].up, vecs[k].fpc);
            #1;
            chk("dir_taken", k, {31'b0, pred_taken}, {31'b0, vecs[k].et});
            chk("dir_target", k, pred_target, vecs[k].etgt);
            chk("dir_cnt", k, mispredict_cnt, vecs[k].ecnt);
            @(posedge clk);
        end

        // Random phase: small PC pool so hits, aliases and evictions are frequent.
        for (int i = 0; i < 8; i++) begin
            pool[i] = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2)
                    | $urandom_range(0, 3);
        end
        pool[7] = pool[7] | 32'hF000_0000;

        @(negedge clk);
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(posedge clk);
        model_reset();

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r   = ($urandom_range(0, 99) == 0);
            uv  = ($urandom_range(0, 3) != 0);
            upc = pool[$urandom_range(0, 7)];
            ut  = $urandom_range(0, 1);
            up  = $urandom_range(0, 1);
            fpc = ($urandom_range(0, 3) == 0) ? upc : pool[$urandom_range(0, 7)];
            drive(r, uv, upc, ut, $urandom & 32'hFFFF_FFFC, up, fpc);
            #1;
            model_predict(fpc, et, etgt);
            chk("rnd_taken", n, {31'b0, pred_taken}, {31'b0, et});
            chk("rnd_target", n, pred_target, etgt);
            chk("rnd_cnt", n, mispredict_cnt, m_cnt);
            @(posedge clk);
            model_update(r, uv, upc, ut, update_target, up);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
